// File: rtl/instruction_sequencer_pkg.sv
// Shared types and helpers for the instruction sequencer: FSM encoding and
// address-alignment masks.
package instruction_sequencer_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } sequencer_fsm_t;

    // Mask that clears the lowest 'lsbs' address bits.
    function automatic logic [XLEN-1:0] align_mask(input int unsigned lsbs);
        logic [XLEN-1:0] mask;
        mask = '1;
        return mask << lsbs;
    endfunction

endpackage

// File: rtl/instruction_sequencer_bundle_fifo.sv
// Small power-of-two FIFO holding fetched bundles; supports same-cycle
// push/pop and a synchronous flush that wins over both.
module bundle_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  logic [WIDTH-1:0]       data_i,
    output logic [WIDTH-1:0]       head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count == FULL_COUNT);
    assign empty_o = (count == '0);
    assign count_o = count;
    assign head_o  = mem[rd_ptr];
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= data_i;
    end

endmodule

// File: rtl/instruction_sequencer.sv
// Fetch-side sequencer: requests aligned blocks, buffers returned bundles and
// issues one word per cycle to decode; redirects flush and cancel fetches.
module instruction_sequencer
    import instruction_sequencer_pkg::*;
#(
    parameter int          BLOCK_WIDTH = 8,
    parameter int          DEPTH       = 2,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic                        redirect_i,
    input  logic [31:0]                 redirect_pc_i,
    output logic                        fetch_o,
    output logic [31:0]                 program_counter_o,
    output logic                        invalidate_o,
    input  logic                        stall_fetch_i,
    input  logic [BLOCK_WIDTH-1:0][31:0] bundle_i,
    input  logic                        bundle_valid_i,
    output logic [31:0]                 instruction_o,
    output logic [31:0]                 pc_o,
    output logic                        valid_o,
    input  logic                        ready_i,
    output sequencer_fsm_t              state_o
);
    localparam int          OFFSET      = $clog2(BLOCK_WIDTH);
    localparam int          ENTRY_W     = XLEN * (BLOCK_WIDTH + 1);
    localparam int          CNT_W       = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [31:0] BLOCK_BYTES = 32'(BLOCK_WIDTH * 4);
    localparam logic [31:0] FETCH_MASK  = align_mask(OFFSET + 2);
    localparam logic [31:0] ISSUE_MASK  = align_mask(2);

    sequencer_fsm_t state, state_next;
    logic [31:0]                  fetch_pc;
    logic [31:0]                  issue_pc;
    logic [ENTRY_W-1:0]           head_entry;
    logic [BLOCK_WIDTH-1:0][31:0] head_words;
    logic [31:0]                  head_base;
    logic [CNT_W-1:0]             fifo_count;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic                         fetch_ok;
    logic                         push;
    logic                         pop;
    logic                         handshake;
    logic [OFFSET-1:0]            word_idx;

    // Decode handshake: a word transfers on a cycle where valid_o && ready_i;
    // valid_o never looks at ready_i, and a redirect drops valid_o that cycle.
    assign valid_o    = !fifo_empty && !redirect_i;
    assign handshake  = valid_o && ready_i;
    assign word_idx   = issue_pc[OFFSET+1:2];
    assign head_words = head_entry[BLOCK_WIDTH*32-1:0];
    assign head_base  = head_entry[ENTRY_W-1 -: 32];
    assign fetch_ok   = (fifo_count < DEPTH_CNT) && !stall_fetch_i;
    assign push       = (state == WAIT) && bundle_valid_i && !redirect_i && !fifo_full;
    assign pop        = handshake && (word_idx == {OFFSET{1'b1}});
    assign state_o    = state;

    bundle_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_i),
        .data_i  ({fetch_pc, bundle_i}),
        .head_o  (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (redirect_i) begin
            state_next = ((state == WAIT) || stall_fetch_i) ? DISCARD : IDLE;
        end else begin
            case (state)
                IDLE:    if (fetch_ok)       state_next = WAIT;
                WAIT:    if (bundle_valid_i) state_next = IDLE;
                DISCARD: if (!stall_fetch_i) state_next = IDLE;
                default:                     state_next = IDLE;
            endcase
        end
    end

    // Request side is held quiet while reset is asserted, even though the
    // registered state already reads IDLE.
    always_comb begin
        fetch_o           = 1'b0;
        invalidate_o      = 1'b0;
        program_counter_o = '0;
        if (rst_n_i) begin
            if (redirect_i) begin
                invalidate_o = (state == WAIT) || stall_fetch_i;
            end else if ((state == IDLE) && fetch_ok) begin
                fetch_o           = 1'b1;
                program_counter_o = fetch_pc;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fetch_pc <= RESET_PC & FETCH_MASK;
            issue_pc <= RESET_PC & ISSUE_MASK;
        end else if (redirect_i) begin
            fetch_pc <= redirect_pc_i & FETCH_MASK;
            issue_pc <= redirect_pc_i & ISSUE_MASK;
        end else begin
            if (push)      fetch_pc <= fetch_pc + BLOCK_BYTES;
            if (handshake) issue_pc <= issue_pc + 32'd4;
        end
    end

    // The head's stored base supplies the block part of pc_o; issue_pc always
    // tracks the same block, so only its in-block offset is needed here.
    always_comb begin
        instruction_o = '0;
        pc_o          = '0;
        if (valid_o) begin
            instruction_o = head_words[word_idx];
            pc_o          = {head_base[31:OFFSET+2], issue_pc[OFFSET+1:0]};
        end
    end

endmodule
